rc4_key_expander: RTL and testbench
===================================

Name: rc4_key_expander

Overview:
Upstream feeder for the RC4 core's key interface. Accepts a variable-length key (1..MAX_KEY_LEN bytes) over a byte handshake and stores it in a local register file. It then replays exactly 256 key bytes, K[i mod key_len] for i = 0..255, into the RC4 key-scheduling handshake. This removes key-length handling and modulo indexing from the RC4 core.

Parameters:
MAX_KEY_LEN, 16, maximum key bytes stored; legal range 1..256.
LEN_W, $clog2(MAX_KEY_LEN+1), width of length and load counters (derived; do not override).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
load_valid  in  1  key byte offered by host
load_ready  out  1  block can accept a key byte
load_byte  in  8  key byte
load_last  in  1  qualifies load_byte as the final key byte
key_rvalid  out  1  key byte valid toward RC4 core
key_rready  in  1  RC4 core accepts key byte
key_out  out  8  key byte K[i mod key_len]
key_last  out  1  high with the 256th streamed byte (i = 255)
key_len  out  LEN_W  length of the currently held key; 0 if none
trunc_err  out  1  one-cycle pulse when key is truncated at MAX_KEY_LEN
busy  out  1  high in any state other than LOAD

Behaviour:
- Reset (rst = 0, asynchronous): state = LOAD, load_ready = 1, key_rvalid = 0, key_last = 0, key_out = 0, key_len = 0, trunc_err = 0, busy = 0, all counters 0. Key memory is not cleared by reset.
- Handshakes: a transfer occurs on a rising edge with valid & ready both high. key_out, key_last and key_rvalid are registered. While key_rvalid = 1 and key_rready = 0, key_out and key_last hold stable.
- State LOAD:
  - load_ready = 1.
  - Each accepted byte is written to mem[wr_cnt]; wr_cnt then increments.
  - Exit condition: the accepted byte has load_last = 1, or it is byte number MAX_KEY_LEN. On exit, key_len is set to wr_cnt+1, wr_cnt is cleared, and the state moves to STREAM.
  - If the exit is caused by byte MAX_KEY_LEN with load_last = 0, trunc_err pulses high in the following cycle. Later host bytes wait with load_ready = 0 and are treated as the next key.
- STREAM entry: key_rvalid rises on the cycle after the final load handshake (latency 1), with key_out = mem[0].
- State STREAM:
  - load_ready = 0.
  - On each key handshake: out_cnt (8-bit) increments; rd_idx increments and wraps to 0 when rd_idx = key_len-1; key_out is updated to mem[next rd_idx].
  - key_last = 1 exactly while out_cnt = 255.
  - On the handshake with out_cnt = 255: key_rvalid drops next cycle, out_cnt and rd_idx clear, and the state returns to LOAD (or ZERO, see Optional Feature).
- Exactly 256 handshakes per key, regardless of backpressure.
- key_len holds its value until the next key load completes.
- key_len = 1: every streamed byte equals mem[0]. key_len = 256 (MAX_KEY_LEN = 256): no wrap occurs.
- load_valid is ignored outside LOAD; no bytes are dropped because load_ready is 0 there.
- Reset asserted mid-LOAD or mid-STREAM aborts immediately to reset values. The partial stream is abandoned, and the RC4 core must be reset alongside.

Optional Feature:
Macro RC4_KEY_ZEROIZE_EN.
- Defined: after the final STREAM handshake, enter state ZERO. ZERO clears mem[0..MAX_KEY_LEN-1], one entry per cycle, over MAX_KEY_LEN cycles. During ZERO: busy = 1, load_ready = 0, key_len = 0. The block then returns to LOAD. Reset during ZERO goes to LOAD with zeroization incomplete.
- Undefined: the ZERO state and its clear logic are absent; STREAM returns directly to LOAD and key material stays in mem.

Test Plan:
- Load 0x01, 0x02, 0x03 (last on 0x03), key_rready = 1 -> 256 bytes 01 02 03 repeating; byte 255 = 0x01 with key_last = 1; key_len = 3; key_rvalid falls after byte 255.
- Load single byte 0xAA with load_last, key_rready = 1 -> 256 bytes of 0xAA; key_rvalid first high 1 cycle after the load handshake.
- 3-byte key with key_rready toggled pseudo-randomly -> key_out and key_last stable while stalled; exactly 256 handshakes; sequence identical to scenario 1.
- MAX_KEY_LEN = 16, 17 bytes 0x00..0x10 with no load_last -> trunc_err pulses once after byte 0x0F; key_len = 16; stream is 00..0F repeating; load_ready = 0 during STREAM; byte 0x10 accepted after return to LOAD as the first byte of the next key.
- rst pulled low at stream byte 100 -> key_rvalid = 0, key_len = 0, load_ready = 1 asynchronously. A new key of 0x55 then streams 256 x 0x55.
- With RC4_KEY_ZEROIZE_EN, key 0x11, 0x22 -> after 256 bytes, busy stays high and load_ready = 0 for 16 cycles, then all mem = 0x00 (via hierarchical peek) and load_ready = 1.

Source files
------------

// File: rtl/rc4_key_expander_if.sv
// Handshake bundle between the key host, the key expander and the RC4 core.
// The master drives key bytes in and accepts the expanded stream; the slave is the expander.
interface rc4_key_expander_if;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_byte;
    logic       load_last;
    logic       key_rvalid;
    logic       key_rready;
    logic [7:0] key_out;
    logic       key_last;

    modport master (
        output load_valid, load_byte, load_last, key_rready,
        input  load_ready, key_rvalid, key_out, key_last
    );

    modport slave (
        input  load_valid, load_byte, load_last, key_rready,
        output load_ready, key_rvalid, key_out, key_last
    );
endinterface

// File: rtl/rc4_key_expander.sv
// Stores a 1..MAX_KEY_LEN byte key, then replays K[i mod key_len] for i = 0..255 to the RC4 core.
// Optional macro RC4_KEY_ZEROIZE_EN: wipe the key memory after every 256-byte stream.
module rc4_key_expander #(
    parameter int MAX_KEY_LEN = 16,
    localparam int LEN_W = $clog2(MAX_KEY_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    rc4_key_expander_if.slave    kif,
    output logic [LEN_W-1:0]     key_len,
    output logic                 trunc_err,
    output logic                 busy
);
    localparam int AW = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;

`ifdef RC4_KEY_ZEROIZE_EN
    typedef enum logic [1:0] {S_LOAD, S_STREAM, S_ZERO} state_t;
`else
    typedef enum logic [1:0] {S_LOAD, S_STREAM} state_t;
`endif

    state_t state_reg, state_next;

    logic [7:0]       mem [MAX_KEY_LEN];
    logic [LEN_W-1:0] wr_cnt_reg;
    logic [LEN_W-1:0] rd_idx_reg;
    logic [LEN_W-1:0] rd_idx_next;
    logic [LEN_W-1:0] key_len_reg;
    logic [7:0]       out_cnt_reg;
    logic [7:0]       key_out_reg;
    logic             key_rvalid_reg;
    logic             key_last_reg;
    logic             trunc_err_reg;
    logic             load_ready;

    logic             load_fire;
    logic             load_exit;
    logic             wr_at_max;
    logic             key_fire;
    logic             stream_done;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [7:0]       mem_wdata;

`ifdef RC4_KEY_ZEROIZE_EN
    logic [AW-1:0]    zero_cnt_reg;
    logic             zero_done;
    assign zero_done = (zero_cnt_reg == AW'(MAX_KEY_LEN - 1));
`endif

    assign wr_at_max   = (wr_cnt_reg == LEN_W'(MAX_KEY_LEN - 1));
    assign load_fire   = kif.load_valid & (state_reg == S_LOAD);
    assign load_exit   = load_fire & (kif.load_last | wr_at_max);
    assign key_fire    = key_rvalid_reg & kif.key_rready;
    assign stream_done = key_fire & (out_cnt_reg == 8'd255);
    assign rd_idx_next = (rd_idx_reg == key_len_reg - LEN_W'(1)) ? '0 : rd_idx_reg + LEN_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_LOAD;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_ready = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            S_LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b0;
                if (load_exit) state_next = S_STREAM;
            end
            S_STREAM: begin
`ifdef RC4_KEY_ZEROIZE_EN
                if (stream_done) state_next = S_ZERO;
`else
                if (stream_done) state_next = S_LOAD;
`endif
            end
`ifdef RC4_KEY_ZEROIZE_EN
            S_ZERO: begin
                if (zero_done) state_next = S_LOAD;
            end
`endif
            default: state_next = S_LOAD;
        endcase
    end

    // Single write port shared by key loading and zeroization
    always_comb begin
        mem_we    = load_fire;
        mem_waddr = wr_cnt_reg[AW-1:0];
        mem_wdata = kif.load_byte;
`ifdef RC4_KEY_ZEROIZE_EN
        if (state_reg == S_ZERO) begin
            mem_we    = 1'b1;
            mem_waddr = zero_cnt_reg;
            mem_wdata = 8'h00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_reg     <= '0;
            rd_idx_reg     <= '0;
            key_len_reg    <= '0;
            out_cnt_reg    <= '0;
            key_out_reg    <= '0;
            key_rvalid_reg <= 1'b0;
            key_last_reg   <= 1'b0;
            trunc_err_reg  <= 1'b0;
        end else begin
            trunc_err_reg <= 1'b0;
            if (load_fire) begin
                if (load_exit) begin
                    wr_cnt_reg     <= '0;
                    key_len_reg    <= wr_cnt_reg + LEN_W'(1);
                    rd_idx_reg     <= '0;
                    out_cnt_reg    <= '0;
                    key_rvalid_reg <= 1'b1;
                    key_last_reg   <= 1'b0;
                    trunc_err_reg  <= ~kif.load_last;
                    // A one-byte key is written on this same edge, so bypass the memory
                    key_out_reg    <= (wr_cnt_reg == '0) ? kif.load_byte : mem[0];
                end else begin
                    wr_cnt_reg <= wr_cnt_reg + LEN_W'(1);
                end
            end
            if (key_fire) begin
                if (out_cnt_reg == 8'd255) begin
                    key_rvalid_reg <= 1'b0;
                    key_last_reg   <= 1'b0;
                    out_cnt_reg    <= '0;
                    rd_idx_reg     <= '0;
`ifdef RC4_KEY_ZEROIZE_EN
                    key_len_reg    <= '0;
`endif
                end else begin
                    out_cnt_reg  <= out_cnt_reg + 8'd1;
                    key_last_reg <= (out_cnt_reg == 8'd254);
                    rd_idx_reg   <= rd_idx_next;
                    key_out_reg  <= mem[rd_idx_next[AW-1:0]];
                end
            end
        end
    end

`ifdef RC4_KEY_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    zero_cnt_reg <= '0;
        else if (state_reg != S_ZERO) zero_cnt_reg <= '0;
        else                         zero_cnt_reg <= zero_cnt_reg + AW'(1);
    end
`endif

    assign kif.load_ready = load_ready;
    assign kif.key_rvalid = key_rvalid_reg;
    assign kif.key_out    = key_out_reg;
    assign kif.key_last   = key_last_reg;
    assign key_len        = key_len_reg;
    assign trunc_err      = trunc_err_reg;
endmodule

// File: tb/tb_rc4_key_expander.sv
// Scoreboard bench for rc4_key_expander: expected streams are queued at load time and
// popped by a negedge monitor on every key handshake. Define RC4_KEY_ZEROIZE_EN to cover wiping.
module tb_rc4_key_expander;
    localparam int MAXK  = 16;
    localparam int LEN_W = $clog2(MAXK + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [LEN_W-1:0] key_len;
    logic             trunc_err;
    logic             busy;

    rc4_key_expander_if kif ();

    rc4_key_expander #(.MAX_KEY_LEN(MAXK)) dut (
        .clk       (clk),
        .rst       (rst),
        .kif       (kif),
        .key_len   (key_len),
        .trunc_err (trunc_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          hs_count = 0;
    int          trunc_count = 0;
    logic [8:0]  exp_q [$];
    logic [7:0]  key_buf [256];
    logic        stalled = 1'b0;
    logic [7:0]  prev_out;
    logic        prev_last;

    // Scoreboard monitor: a handshake happens at the next posedge when valid & ready here
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (stalled && kif.key_rvalid === 1'b1) begin
                checks++;
                if (kif.key_out !== prev_out || kif.key_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: out=%02h last=%0b required out=%02h last=%0b",
                             kif.key_out, kif.key_last, prev_out, prev_last);
                end
            end
            if (kif.key_rvalid === 1'b1 && kif.key_rready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_handshake: out=%02h last=%0b required no transfer",
                             kif.key_out, kif.key_last);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({kif.key_last, kif.key_out} !== e) begin
                        errors++;
                        $display("FAIL stream_byte #%0d: out=%02h last=%0b required out=%02h last=%0b",
                                 255 - exp_q.size(), kif.key_out, kif.key_last, e[7:0], e[8]);
                    end
                end
                hs_count++;
            end
            stalled   = (kif.key_rvalid === 1'b1) && (kif.key_rready !== 1'b1);
            prev_out  = kif.key_out;
            prev_last = kif.key_last;
            if (trunc_err === 1'b1) trunc_count++;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic push_expected(input int len);
        for (int i = 0; i < 256; i++)
            exp_q.push_back({(i == 255), key_buf[i % len]});
    endtask

    task automatic send_key(input int n, input bit last_final, output int waited);
        int budget;
        waited = 0;
        for (int i = 0; i < n; i++) begin
            kif.load_valid = 1'b1;
            kif.load_byte  = key_buf[i];
            kif.load_last  = last_final && (i == n - 1);
            budget = 0;
            while (kif.load_ready !== 1'b1 && budget < 2000) begin
                @(posedge clk); #2;
                budget++;
                waited++;
            end
            if (budget >= 2000) begin
                errors++; checks++;
                $display("FAIL load_timeout: load_ready=%b required 1 within 2000 cycles", kif.load_ready);
            end
            @(posedge clk); #2;
        end
        kif.load_valid = 1'b0;
        kif.load_last  = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 3000) begin
            kif.key_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #2;
            budget++;
        end
        kif.key_rready = 1'b1;
        if (budget >= 3000) begin
            errors++; checks++;
            $display("FAIL drain_timeout: %0d bytes left required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        kif.load_valid = 1'b0; kif.load_byte = 8'h00; kif.load_last = 1'b0; kif.key_rready = 1'b0;
        repeat (2) @(posedge clk); #2;
        checks++;
        if ({kif.load_ready, kif.key_rvalid, kif.key_last, kif.key_out, key_len, trunc_err, busy}
            !== {1'b1, 1'b0, 1'b0, 8'h00, LEN_W'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: ready=%b rvalid=%b last=%b out=%02h len=%0d trunc=%b busy=%b required 1 0 0 00 0 0 0",
                     kif.load_ready, kif.key_rvalid, kif.key_last, kif.key_out, key_len, trunc_err, busy);
        end
        rst = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_three_byte(input bit rnd);
        int w, hs0;
        key_buf[0] = 8'h01; key_buf[1] = 8'h02; key_buf[2] = 8'h03;
        kif.key_rready = 1'b1;
        push_expected(3);
        hs0 = hs_count;
        send_key(3, 1'b1, w);
        checks++;
        if (kif.key_rvalid !== 1'b1 || kif.key_out !== 8'h01) begin
            errors++;
            $display("FAIL first_byte_latency: rvalid=%b out=%02h required 1 01", kif.key_rvalid, kif.key_out);
        end
        checks++;
        if (key_len !== LEN_W'(3)) begin
            errors++;
            $display("FAIL key_len_3: got %0d required 3", key_len);
        end
        drain(rnd);
        checks++;
        if (hs_count - hs0 !== 256) begin
            errors++;
            $display("FAIL handshake_count: got %0d required 256", hs_count - hs0);
        end
`ifdef RC4_KEY_ZEROIZE_EN
        checks++;
        if ({kif.key_rvalid, kif.load_ready, busy} !== 3'b001) begin
            errors++;
            $display("FAIL after_stream: rvalid=%b ready=%b busy=%b required 0 0 1", kif.key_rvalid, kif.load_ready, busy);
        end
`else
        checks++;
        if ({kif.key_rvalid, kif.load_ready, busy, key_len} !== {3'b010, LEN_W'(3)}) begin
            errors++;
            $display("FAIL after_stream: rvalid=%b ready=%b busy=%b len=%0d required 0 1 0 3",
                     kif.key_rvalid, kif.load_ready, busy, key_len);
        end
`endif
    endtask

    task automatic test_single_byte;
        int w;
        key_buf[0] = 8'hAA;
        kif.key_rready = 1'b1;
        push_expected(1);
        send_key(1, 1'b1, w);
        checks++;
        if (kif.key_rvalid !== 1'b1 || kif.key_out !== 8'hAA || key_len !== LEN_W'(1)) begin
            errors++;
            $display("FAIL single_byte_entry: rvalid=%b out=%02h len=%0d required 1 aa 1",
                     kif.key_rvalid, kif.key_out, key_len);
        end
        drain(1'b0);
    endtask

    task automatic test_truncation;
        int w;
        trunc_count = 0;
        for (int i = 0; i < MAXK; i++) key_buf[i] = 8'(i);
        kif.key_rready = 1'b1;
        push_expected(MAXK);
        send_key(MAXK, 1'b0, w);
        checks++;
        if (trunc_err !== 1'b1 || key_len !== LEN_W'(MAXK) || kif.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL trunc_entry: trunc=%b len=%0d ready=%b required 1 %0d 0",
                     trunc_err, key_len, kif.load_ready, MAXK);
        end
        // Byte 0x10 is offered during the stream and must become the next key's first byte
        key_buf[0] = 8'h10; key_buf[1] = 8'h77;
        push_expected(2);
        send_key(2, 1'b1, w);
        checks++;
        if (w < 255) begin
            errors++;
            $display("FAIL ready_low_in_stream: waited %0d cycles required >= 255", w);
        end
        checks++;
        if (key_len !== LEN_W'(2)) begin
            errors++;
            $display("FAIL next_key_len: got %0d required 2", key_len);
        end
        drain(1'b0);
        checks++;
        if (trunc_count !== 1) begin
            errors++;
            $display("FAIL trunc_pulse_count: got %0d required 1", trunc_count);
        end
    endtask

    task automatic test_reset_mid_stream;
        int w, budget, hs0;
        key_buf[0] = 8'h01; key_buf[1] = 8'h02; key_buf[2] = 8'h03;
        kif.key_rready = 1'b1;
        push_expected(3);
        send_key(3, 1'b1, w);
        hs0 = hs_count;
        budget = 0;
        while (hs_count - hs0 < 100 && budget < 1000) begin
            @(posedge clk); #2;
            budget++;
        end
        exp_q.delete();
        rst = 1'b0;
        #1;
        checks++;
        if ({kif.key_rvalid, kif.load_ready, key_len} !== {2'b01, LEN_W'(0)}) begin
            errors++;
            $display("FAIL async_reset: rvalid=%b ready=%b len=%0d required 0 1 0",
                     kif.key_rvalid, kif.load_ready, key_len);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        key_buf[0] = 8'h55;
        push_expected(1);
        send_key(1, 1'b1, w);
        drain(1'b0);
    endtask

`ifdef RC4_KEY_ZEROIZE_EN
    task automatic test_zeroize;
        int w, n;
        bit bad;
        key_buf[0] = 8'h11; key_buf[1] = 8'h22;
        kif.key_rready = 1'b1;
        push_expected(2);
        send_key(2, 1'b1, w);
        drain(1'b0);
        n = 0; bad = 1'b0;
        while (kif.load_ready !== 1'b1 && n < 100) begin
            if (busy !== 1'b1 || key_len !== LEN_W'(0)) bad = 1'b1;
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (n !== MAXK || bad) begin
            errors++;
            $display("FAIL zeroize_window: %0d cycles flag=%0b required %0d cycles flag=0", n, bad, MAXK);
        end
        for (int i = 0; i < MAXK; i++) begin
            checks++;
            if (dut.mem[i] !== 8'h00) begin
                errors++;
                $display("FAIL zeroize_mem[%0d]: got %02h required 00", i, dut.mem[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_three_byte(1'b0);
        test_single_byte;
        test_three_byte(1'b1);
        test_truncation;
        test_reset_mid_stream;
`ifdef RC4_KEY_ZEROIZE_EN
        test_zeroize;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
